// File: rtl/vehicle_pkg.sv
// Shared constants for the vehicle counter: debounce FSM encoding, channel indices, count width.
package vehicle_pkg;

    localparam int CNT_W  = 4;
    localparam int NUM_CH = 4;

    localparam int CH_NS = 0;
    localparam int CH_SN = 1;
    localparam int CH_EW = 2;
    localparam int CH_WE = 3;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RISE = 2'b01;
    localparam logic [1:0] ST_HELD = 2'b10;
    localparam logic [1:0] ST_FALL = 2'b11;

    typedef logic [CNT_W-1:0] count_t;

endpackage

// File: rtl/sensor_channel.sv
// One sensor lane: 2-flop synchronizer, debounce FSM, wrapping car count and arrival strobe.
// States: IDLE no car | RISE qualifying arrival | HELD car present | FALL qualifying departure
module sensor_channel
    import vehicle_pkg::*;
#(
    parameter int DEB_CYCLES = 500_000
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   sensor_i,
    input  logic   clr_i,
    output count_t count_o,
    output logic   pulse_o
);

    localparam int DC_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEB_CYCLES - 1);

    logic            s1_q, s2_q;
    logic [1:0]      state_q, state_d;
    logic [DC_W-1:0] dc_q, dc_d;
    count_t          count_q, count_d;
    logic            pulse_q, pulse_d;
    logic            inc;

    always_comb begin
        state_d = state_q;
        dc_d    = dc_q;
        inc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s2_q) begin
                    state_d = ST_RISE;
                    dc_d    = '0;
                end
            end
            ST_RISE: begin
                if (!s2_q) begin
                    state_d = ST_IDLE;
                end else if (dc_q == DC_LAST) begin
                    state_d = ST_HELD;
                    inc     = 1'b1;
                end else begin
                    dc_d = dc_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (!s2_q) begin
                    state_d = ST_FALL;
                    dc_d    = '0;
                end
            end
            ST_FALL: begin
                // A high sample here is release bounce: return to HELD without counting.
                if (s2_q) begin
                    state_d = ST_HELD;
                end else if (dc_q == DC_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    dc_d = dc_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        count_d = clr_i ? '0 : count_q + {{(CNT_W-1){1'b0}}, inc};
        pulse_d = inc;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= ST_IDLE;
            dc_q    <= '0;
            count_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= sensor_i;
            s2_q    <= s1_q;
            state_q <= state_d;
            dc_q    <= dc_d;
            count_q <= count_d;
            pulse_q <= pulse_d;
        end
    end

    assign count_o = count_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/vehicle_counter.sv
// Four independent debounced car counters feeding the intersection controller's count inputs.
module vehicle_counter
    import vehicle_pkg::*;
#(
    parameter int DEB_CYCLES = 500_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sensor_ns,
    input  logic             sensor_sn,
    input  logic             sensor_ew,
    input  logic             sensor_we,
    input  logic             clr,
    output logic [CNT_W-1:0] count_ns_4b,
    output logic [CNT_W-1:0] count_sn_4b,
    output logic [CNT_W-1:0] count_ew_4b,
    output logic [CNT_W-1:0] count_we_4b,
    output logic [NUM_CH-1:0] car_pulse
);

    logic [NUM_CH-1:0] sens;
    count_t            cnt [NUM_CH];

    assign sens[CH_NS] = sensor_ns;
    assign sens[CH_SN] = sensor_sn;
    assign sens[CH_EW] = sensor_ew;
    assign sens[CH_WE] = sensor_we;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sensor_channel #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .sensor_i(sens[g]),
            .clr_i   (clr),
            .count_o (cnt[g]),
            .pulse_o (car_pulse[g])
        );
    end

    assign count_ns_4b = cnt[CH_NS];
    assign count_sn_4b = cnt[CH_SN];
    assign count_ew_4b = cnt[CH_EW];
    assign count_we_4b = cnt[CH_WE];

endmodule

// File: tb/tb_vehicle_counter.sv
// Bench for vehicle_counter with DEB_CYCLES=4: directed scenarios plus random traffic against a run-length model.
module tb_vehicle_counter;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] sens = 4'b0000;
    logic [3:0] count_ns_4b, count_sn_4b, count_ew_4b, count_we_4b;
    logic [3:0] car_pulse;

    int checks = 0;
    int errors = 0;

    // Model: a car counts once the synchronized input has been high for DEB+1 samples
    // while armed; re-arming needs DEB+1 consecutive low samples after an accepted car.
    logic       m_s1 [4];
    logic       m_s2 [4];
    int         hi_run [4];
    int         lo_run [4];
    bit         armed [4];
    logic [3:0] m_cnt [4];
    logic [3:0] m_pulse;

    vehicle_counter #(.DEB_CYCLES(DEB)) dut (
        .clk        (clk),
        .reset      (reset),
        .sensor_ns  (sens[0]),
        .sensor_sn  (sens[1]),
        .sensor_ew  (sens[2]),
        .sensor_we  (sens[3]),
        .clr        (clr),
        .count_ns_4b(count_ns_4b),
        .count_sn_4b(count_sn_4b),
        .count_ew_4b(count_ew_4b),
        .count_we_4b(count_we_4b),
        .car_pulse  (car_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] act_vec();
        return {count_we_4b, count_ew_4b, count_sn_4b, count_ns_4b, car_pulse};
    endfunction

    function automatic logic [19:0] model_vec();
        return {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0], m_pulse};
    endfunction

    function automatic void model_edge();
        if (!reset) begin
            for (int ch = 0; ch < 4; ch++) begin
                m_s1[ch] = 1'b0; m_s2[ch] = 1'b0;
                hi_run[ch] = 0; lo_run[ch] = 0;
                armed[ch] = 1'b1; m_cnt[ch] = 4'd0;
            end
            m_pulse = 4'b0000;
            return;
        end
        m_pulse = 4'b0000;
        for (int ch = 0; ch < 4; ch++) begin
            if (m_s2[ch]) begin
                hi_run[ch]++;
                lo_run[ch] = 0;
                if (armed[ch] && hi_run[ch] == DEB + 1) begin
                    m_cnt[ch] = (m_cnt[ch] + 4'd1) % 16;
                    m_pulse[ch] = 1'b1;
                    armed[ch] = 1'b0;
                end
            end else begin
                lo_run[ch]++;
                hi_run[ch] = 0;
                if (!armed[ch] && lo_run[ch] == DEB + 1) armed[ch] = 1'b1;
            end
            if (clr) m_cnt[ch] = 4'd0;
            m_s2[ch] = m_s1[ch];
            m_s1[ch] = sens[ch];
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; sens = 4'b0000; clr = 1'b0;
        step(); step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        sens = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (act_vec() !== 20'h0) begin
                errors++;
                $display("FAIL reset_state cycle %0d: got %h expected 00000", i, act_vec());
            end
        end
        sens = 4'b0000;
        step();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) step();
    endtask

    task automatic test_single_car();
        logic [19:0] exp;
        do_reset();
        sens = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            step();
            exp = {12'h000, (i >= 6) ? 4'd1 : 4'd0, (i == 6) ? 4'b0001 : 4'b0000};
            checks++;
            if (act_vec() !== exp) begin
                errors++;
                $display("FAIL single_car cycle %0d: got %h expected %h", i, act_vec(), exp);
            end
        end
        sens = 4'b0000;
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_glitch();
        logic [19:0] exp;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            sens = (i < 3) ? 4'b0100 : 4'b0000;
            step();
            checks++;
            if (act_vec() !== 20'h0) begin
                errors++;
                $display("FAIL glitch_reject cycle %0d: got %h expected 00000", i, act_vec());
            end
        end
        for (int i = 0; i < 13; i++) begin
            sens = (i < 5) ? 4'b0100 : 4'b0000;
            step();
            exp = {4'd0, (i >= 6) ? 4'd1 : 4'd0, 8'h00, (i == 6) ? 4'b0100 : 4'b0000};
            checks++;
            if (act_vec() !== exp) begin
                errors++;
                $display("FAIL glitch_then_car cycle %0d: got %h expected %h", i, act_vec(), exp);
            end
        end
    endtask

    task automatic test_release_bounce();
        logic [19:0] exp;
        logic [3:0]  c;
        do_reset();
        for (int i = 0; i < 45; i++) begin
            sens = ((i < 8) || (i == 10) || (i >= 21 && i < 31)) ? 4'b1000 : 4'b0000;
            step();
            c = (i >= 27) ? 4'd2 : (i >= 6) ? 4'd1 : 4'd0;
            exp = {c, 12'h000, (i == 6 || i == 27) ? 4'b1000 : 4'b0000};
            checks++;
            if (act_vec() !== exp) begin
                errors++;
                $display("FAIL release_bounce cycle %0d: got %h expected %h", i, act_vec(), exp);
            end
        end
    endtask

    task automatic test_wrap();
        logic [19:0] exp;
        logic [3:0]  c;
        int          pulses = 0;
        do_reset();
        for (int car = 1; car <= 17; car++) begin
            for (int i = 0; i < 12; i++) begin
                sens = (i < 6) ? 4'b0010 : 4'b0000;
                step();
                if (car_pulse[1]) pulses++;
                c = (i >= 6) ? 4'(car % 16) : 4'((car - 1) % 16);
                exp = {8'h00, c, 4'd0, (i == 6) ? 4'b0010 : 4'b0000};
                checks++;
                if (act_vec() !== exp) begin
                    errors++;
                    $display("FAIL wrap car %0d cycle %0d: got %h expected %h", car, i, act_vec(), exp);
                end
            end
        end
        checks++;
        if (pulses != 17 || count_sn_4b !== 4'd1) begin
            errors++;
            $display("FAIL wrap_total: got pulses %0d count %0d expected pulses 17 count 1", pulses, count_sn_4b);
        end
    endtask

    task automatic test_simultaneous();
        logic [19:0] exp;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            sens = (i < 8) ? 4'b1111 : 4'b0000;
            step();
            exp = (i >= 6) ? {16'h1111, (i == 6) ? 4'b1111 : 4'b0000} : 20'h0;
            checks++;
            if (act_vec() !== exp) begin
                errors++;
                $display("FAIL simultaneous cycle %0d: got %h expected %h", i, act_vec(), exp);
            end
        end
        for (int i = 0; i < 14; i++) begin
            sens = (i < 8) ? 4'b1111 : 4'b0000;
            clr = (i == 6);
            step();
            exp = (i >= 6) ? {16'h0000, (i == 6) ? 4'b1111 : 4'b0000} : 20'h11110;
            checks++;
            if (act_vec() !== exp) begin
                errors++;
                $display("FAIL clr_priority cycle %0d: got %h expected %h", i, act_vec(), exp);
            end
        end
        clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [19:0] exp;
        do_reset();
        for (int car = 0; car < 9; car++) begin
            for (int i = 0; i < 12; i++) begin
                sens = {car < 9, car < 7, car < 5, car < 3} & {4{i < 6}};
                step();
            end
        end
        checks++;
        if (act_vec() !== 20'h97530) begin
            errors++;
            $display("FAIL preload_counts: got %h expected 97530", act_vec());
        end
        sens = 4'b0001;
        step(); step(); step();
        reset = 1'b0;
        step();
        checks++;
        if (act_vec() !== 20'h0) begin
            errors++;
            $display("FAIL reset_mid: got %h expected 00000", act_vec());
        end
        reset = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            exp = {12'h000, (i >= 6) ? 4'd1 : 4'd0, (i == 6) ? 4'b0001 : 4'b0000};
            checks++;
            if (act_vec() !== exp) begin
                errors++;
                $display("FAIL reset_release cycle %0d: got %h expected %h", i, act_vec(), exp);
            end
        end
        sens = 4'b0000;
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_random();
        int run_left [4];
        do_reset();
        for (int ch = 0; ch < 4; ch++) run_left[ch] = 0;
        for (int n = 0; n < 4000; n++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (run_left[ch] == 0) begin
                    sens[ch] = ~sens[ch];
                    run_left[ch] = $urandom_range(1, 9);
                end
                run_left[ch]--;
            end
            clr = ($urandom_range(0, 149) == 0);
            reset = ($urandom_range(0, 799) != 0);
            step();
            checks++;
            if (act_vec() !== model_vec()) begin
                errors++;
                $display("FAIL random cycle %0d: got %h expected %h", n, act_vec(), model_vec());
            end
        end
        clr = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_car();
        test_glitch();
        test_release_bounce();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
